// File: rtl/pb_periph_pkg.sv
// Shared constants for the push-button peripheral and the memory controller's decode.
package pb_periph_pkg;

  localparam logic [3:0] PB_ADDR_LEVEL    = 4'd0;
  localparam logic [3:0] PB_ADDR_RISE     = 4'd1;
  localparam logic [3:0] PB_ADDR_FALL     = 4'd2;
  localparam logic [3:0] PB_ADDR_IRQ_MASK = 4'd3;
  localparam logic [3:0] PB_ADDR_DEB_CFG  = 4'd4;

  localparam logic [15:0] PB_WIN_BASE = 16'h1020;
  localparam logic [15:0] PB_WIN_HIGH = 16'h102F;

endpackage

// File: rtl/pb_debounce.sv
// One button channel: 2-flop synchronizer followed by a counting debouncer.
module pb_debounce #(
  parameter int unsigned DEB_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raw,
  input  logic [DEB_WIDTH-1:0] cfg,
  output logic                 deb
);

  logic                 sync1_q, sync2_q;
  logic                 deb_q, deb_d;
  logic [DEB_WIDTH-1:0] cnt_q, cnt_d;
  logic [DEB_WIDTH-1:0] eff_cfg;

  // A zero threshold is treated as one so a change still needs one stable cycle.
  assign eff_cfg = (cfg == '0) ? DEB_WIDTH'(1) : cfg;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q >= eff_cfg - DEB_WIDTH'(1)) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DEB_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/push_button_periph.sv
// Memory-mapped debounced push buttons with sticky W1C rise/fall flags.
// Define PUSH_BUTTON_IRQ_EN to add the IRQ_MASK register and the irq output.
module push_button_periph
  import pb_periph_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = 5,
  parameter int unsigned DEB_WIDTH   = 20,
  parameter int unsigned DEB_DEFAULT = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  input  logic                   push_button_p_we,
  input  logic [3:0]             push_button_p_addr,
  input  logic [31:0]            push_button_p_in,
  output logic [31:0]            push_button_p_out
`ifdef PUSH_BUTTON_IRQ_EN
  ,
  output logic                   irq
`endif
);

  logic [NUM_BUTTONS-1:0] deb, deb_prev_q;
  logic [NUM_BUTTONS-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [NUM_BUTTONS-1:0] wdata_btn;
  logic [DEB_WIDTH-1:0]   cfg_q, cfg_d;
  logic [31:0]            rdata;
  logic                   wr_rise, wr_fall, wr_cfg;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    pb_debounce #(
      .DEB_WIDTH(DEB_WIDTH)
    ) u_deb (
      .clk(clk),
      .rst(rst),
      .raw(btn_raw[i]),
      .cfg(cfg_q),
      .deb(deb[i])
    );
  end

  assign wdata_btn = push_button_p_in[NUM_BUTTONS-1:0];
  assign wr_rise   = push_button_p_we && (push_button_p_addr == PB_ADDR_RISE);
  assign wr_fall   = push_button_p_we && (push_button_p_addr == PB_ADDR_FALL);
  assign wr_cfg    = push_button_p_we && (push_button_p_addr == PB_ADDR_DEB_CFG);

  // New events are OR-ed in after the clear so a same-cycle set wins.
  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    cfg_d  = cfg_q;
    if (wr_rise) rise_d = rise_d & ~wdata_btn;
    if (wr_fall) fall_d = fall_d & ~wdata_btn;
    if (wr_cfg)  cfg_d  = push_button_p_in[DEB_WIDTH-1:0];
    rise_d = rise_d | (deb & ~deb_prev_q);
    fall_d = fall_d | (~deb & deb_prev_q);
  end

`ifdef PUSH_BUTTON_IRQ_EN
  logic [NUM_BUTTONS-1:0] mask_q;
  logic                   irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (push_button_p_we && (push_button_p_addr == PB_ADDR_IRQ_MASK)) mask_q <= wdata_btn;
      irq_q <= |((rise_q | fall_q) & mask_q);
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    case (push_button_p_addr)
      PB_ADDR_LEVEL:    rdata[NUM_BUTTONS-1:0] = deb;
      PB_ADDR_RISE:     rdata[NUM_BUTTONS-1:0] = rise_q;
      PB_ADDR_FALL:     rdata[NUM_BUTTONS-1:0] = fall_q;
`ifdef PUSH_BUTTON_IRQ_EN
      PB_ADDR_IRQ_MASK: rdata[NUM_BUTTONS-1:0] = mask_q;
`endif
      PB_ADDR_DEB_CFG:  rdata[DEB_WIDTH-1:0]   = cfg_q;
      default:          rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_prev_q        <= '0;
      rise_q            <= '0;
      fall_q            <= '0;
      cfg_q             <= DEB_WIDTH'(DEB_DEFAULT);
      push_button_p_out <= '0;
    end else begin
      deb_prev_q        <= deb;
      rise_q            <= rise_d;
      fall_q            <= fall_d;
      cfg_q             <= cfg_d;
      push_button_p_out <= rdata;
    end
  end

  // Upper write-data bits have no destination.
  logic unused_wdata;
  assign unused_wdata = ^push_button_p_in;

endmodule

// File: tb/tb_push_button_periph.sv
// Scoreboard bench for push_button_periph; define PUSH_BUTTON_IRQ_EN to cover irq.
module tb_push_button_periph;

  localparam int unsigned NB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic          we;
  logic [3:0]    addr;
  logic [31:0]   din;
  logic [31:0]   dout;
`ifdef PUSH_BUTTON_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  push_button_periph #(
    .NUM_BUTTONS(NB),
    .DEB_WIDTH  (20),
    .DEB_DEFAULT(1000000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .btn_raw           (btn_raw),
    .push_button_p_we  (we),
    .push_button_p_addr(addr),
    .push_button_p_in  (din),
    .push_button_p_out (dout)
`ifdef PUSH_BUTTON_IRQ_EN
    ,
    .irq               (irq)
`endif
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t          sb[$];
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [NB-1:0] btn      = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // One bus cycle: drive at negedge, queue the expected read, compare after the posedge.
  task automatic step(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input bit chk, input logic [31:0] exp, input string tag);
    exp_t e;
    @(negedge clk);
    btn_raw = btn;
    we      = w;
    addr    = a;
    din     = d;
    e.chk = chk;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk) check_eq(e.tag, dout, e.exp);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, "idle");
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    step(1'b0, a, 32'd0, 1'b1, exp, tag);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 32'd0, "wr");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    btn_raw = '0;
    we      = 1'b0;
    addr    = '0;
    din     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out", dout, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    rd(4'd4, 32'h000F4240, "rst_cfg");
    rd(4'd0, 32'd0, "rst_level");
    rd(4'd1, 32'd0, "rst_rise");
    rd(4'd2, 32'd0, "rst_fall");
    rd(4'd3, 32'd0, "rst_addr3");

    wr(4'd4, 32'd4);
    rd(4'd4, 32'd4, "cfg_rd");

    // Raw edge lands before posedge 1: deb flips at posedge 6, visible on the bus after posedge 7.
    btn = 5'b00001;
    for (int k = 1; k <= 8; k++)
      step(1'b0, 4'd0, 32'd0, 1'b1, (k >= 7) ? 32'd1 : 32'd0, $sformatf("rise_lat%0d", k));
    rd(4'd1, 32'd1, "rise0");

    btn = 5'b00011;
    idle(3);
    btn = 5'b00001;
    idle(8);
    rd(4'd0, 32'd1, "glitch_level");
    rd(4'd1, 32'd1, "glitch_rise");

    btn = 5'b00000;
    idle(8);
    rd(4'd2, 32'd1, "fall0");
    rd(4'd0, 32'd0, "level_low");
    wr(4'd2, 32'd1);
    rd(4'd2, 32'd0, "fall_w1c");
    rd(4'd1, 32'd1, "rise_kept");
    wr(4'd0, 32'hFFFF_FFFF);
    rd(4'd0, 32'd0, "level_ro");

    // Rise event for btn1 is pending during step 7; the clear must lose.
    btn = 5'b00010;
    idle(6);
    wr(4'd1, 32'd2);
    rd(4'd1, 32'd3, "race_set_wins");
    wr(4'd1, 32'd2);
    rd(4'd1, 32'd1, "rise_w1c");

    btn = 5'b00101;
    idle(8);
    step(1'b0, 4'd0, 32'd0, 1'b1, 32'd5, "level_05");
    step(1'b1, 4'd1, 32'd1, 1'b1, 32'd5, "rd_pre_write");
    rd(4'd1, 32'd4, "rise_after_wr");
    rd(4'd2, 32'd2, "fall1");

    wr(4'd4, 32'd0);
    rd(4'd4, 32'd0, "cfg_zero");
    btn = 5'b00000;
    for (int k = 1; k <= 5; k++)
      step(1'b0, 4'd0, 32'd0, 1'b1, (k >= 4) ? 32'd0 : 32'd5, $sformatf("cfg0_lat%0d", k));

    wr(4'd4, 32'hFFFF_FFFF);
    rd(4'd4, 32'h000F_FFFF, "cfg_width");
    wr(4'd7, 32'hFFFF_FFFF);
    rd(4'd7, 32'd0, "addr7_zero");
`ifndef PUSH_BUTTON_IRQ_EN
    wr(4'd3, 32'hFFFF_FFFF);
    rd(4'd3, 32'd0, "addr3_zero");
`endif

    // Threshold drops from 10 to 2 mid-count; the kept count flips deb at posedge 6.
    wr(4'd4, 32'd10);
    btn = 5'b01000;
    for (int k = 1; k <= 4; k++)
      step(1'b0, 4'd0, 32'd0, 1'b1, 32'd0, $sformatf("mid_lvl%0d", k));
    step(1'b1, 4'd4, 32'd2, 1'b1, 32'd10, "cfg_pre_write");
    step(1'b0, 4'd0, 32'd0, 1'b1, 32'd0, "mid_lvl6");
    step(1'b0, 4'd0, 32'd0, 1'b1, 32'd8, "mid_lvl7");

`ifdef PUSH_BUTTON_IRQ_EN
    wr(4'd4, 32'd4);
    wr(4'd1, 32'hFFFF_FFFF);
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd3, 32'd4);
    rd(4'd3, 32'd4, "mask_rd");
    idle(2);
    check_eq("irq_idle", {31'd0, irq}, 32'd0);
    // RISE[2] sets at posedge 7, irq follows at posedge 8.
    btn = 5'b01100;
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      check_eq($sformatf("irq_set%0d", k), {31'd0, irq}, (k >= 8) ? 32'd1 : 32'd0);
    end
    wr(4'd1, 32'd4);
    check_eq("irq_clr_wr", {31'd0, irq}, 32'd1);
    idle(1);
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
    btn = 5'b01101;
    idle(9);
    check_eq("irq_masked", {31'd0, irq}, 32'd0);
    rd(4'd1, 32'd1, "rise_masked");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/push_button_periph.md
Name: push_button_periph

Overview:
- Memory-mapped push-button peripheral on the push-button window (0x1020–0x102F) of the memory controller.
- Synchronizes and debounces NUM_BUTTONS raw board buttons.
- Exposes the debounced level and sticky rise/fall event flags; event flags are write-1-to-clear.
- Read data is registered: one-cycle latency, matching the controller's registered read-address mux. The controller is extended to drive push_button_p_we/push_button_p_in for this window.

Parameters:
- NUM_BUTTONS, 5, number of button inputs (1..32).
- DEB_WIDTH, 20, width of debounce counters and of the DEB_CFG register.
- DEB_DEFAULT, 1000000, reset value of DEB_CFG in clk cycles (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  NUM_BUTTONS  asynchronous raw button pins.
- push_button_p_we  in  1  write strobe from the memory controller.
- push_button_p_addr  in  4  word address within the window.
- push_button_p_in  in  32  write data.
- push_button_p_out  out  32  registered read data.

Behaviour:
- Register map (push_button_p_addr):
  - 0 LEVEL: RO, [N-1:0] = debounced level.
  - 1 RISE: sticky 0->1 events, write-1-to-clear.
  - 2 FALL: sticky 1->0 events, write-1-to-clear.
  - 4 DEB_CFG: R/W, [DEB_WIDTH-1:0].
  - 3 (without macro) and 5..15: read 0, writes ignored.
  - Unused upper bits of every register read 0.
- Reset (rst=0, asynchronous):
  - sync flops, debounced levels, RISE, FALL and counters = 0.
  - DEB_CFG = DEB_DEFAULT; push_button_p_out = 0.
- Synchronizer: 2-flop chain per button; debounce logic sees only the second-stage output sync[i].
- Debounce, per button i, counter cnt[i]:
  - if sync[i]==deb[i]: cnt <= 0.
  - else if cnt >= eff_cfg-1: deb[i] <= sync[i], cnt <= 0.
  - else: cnt <= cnt+1.
  - eff_cfg = max(DEB_CFG,1), so DEB_CFG=0 behaves as 1.
  - A stable change propagates to deb exactly eff_cfg cycles after sync first differs; raw-to-deb latency is eff_cfg+2.
  - Any glitch shorter than eff_cfg cycles is rejected.
  - Writing DEB_CFG mid-count takes effect the next cycle; the running count is kept, so cnt >= new eff_cfg-1 flips immediately.
- Events:
  - deb 0->1 sets RISE[i]; deb 1->0 sets FALL[i].
  - Write with data W to RISE/FALL: bits with W[i]=1 clear, others unchanged.
  - Same-cycle set and clear on a bit: set wins.
- Read:
  - Each cycle, push_button_p_out <= register selected by push_button_p_addr, sampled before that edge's updates.
  - A read issued the same cycle as a write returns the pre-write value.
  - Data is valid the cycle after the address is presented.
  - Reads have no side effects. Address 0 is driven whenever the window is idle, so read-clear is deliberately not used.
- Writes occur only when push_button_p_we=1; writes to LEVEL are ignored.

Optional Feature:
- Macro PUSH_BUTTON_IRQ_EN.
- Defined:
  - adds output irq (1 bit, registered, reset 0) and register 3 IRQ_MASK (R/W, [N-1:0], reset 0).
  - irq <= |((RISE|FALL) & IRQ_MASK); asserts the cycle after a flag sets and deasserts the cycle after the clearing write.
- Undefined: no irq port; address 3 reads 0 and ignores writes.

Decomposition:
- Package pb_periph_pkg holds:
  - address constants PB_ADDR_LEVEL=0, PB_ADDR_RISE=1, PB_ADDR_FALL=2, PB_ADDR_IRQ_MASK=3, PB_ADDR_DEB_CFG=4.
  - window base/high constants 0x1020/0x102F, shared with the memory controller.
- Sub-module pb_debounce: one channel, containing the 2-flop sync, counter and deb flop; ports clk, rst, raw, cfg, deb.
  - Instantiated NUM_BUTTONS times via generate.
  - Edge detect and register file stay in the top module.

Test Plan:
- Reset values: hold rst=0, then release. Read addr 4 -> 0x000F4240; read addrs 0, 1, 2 -> 0.
- Debounce threshold: write DEB_CFG=4.
  - btn_raw[0]=1 held -> LEVEL bit 0 set exactly 6 cycles after the edge; RISE reads 0x1.
  - A 3-cycle pulse on btn_raw[1] -> LEVEL and RISE unchanged.
- Fall and W1C: release btn0 -> FALL=0x1. Write 0x1 to addr 2 -> FALL=0; RISE still 0x1.
- Set-versus-clear race: write 0x2 to RISE in the same cycle deb[1] rises -> RISE bit 1 reads 1.
- Read latency: with addr=0 at cycle t and deb=0x05, push_button_p_out=0x05 at t+1. Write 0x1 to RISE with simultaneous read of addr 1 -> that read returns the pre-write value.
- With PUSH_BUTTON_IRQ_EN:
  - IRQ_MASK=0x4, press btn2 -> irq=1 one cycle after RISE[2] sets.
  - Clear RISE[2] -> irq=0 next cycle.
  - Press btn0 (masked) -> irq stays 0.
